// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and the common data bus broadcast record used by the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int FU_COUNT_DEF = 4;
  localparam int CDB_PORTS    = 2;
  localparam int PREG_W       = 6;
  localparam int ROB_W        = 5;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] rd;
    logic [ROB_W-1:0]  rob_id;
    logic [31:0]       value;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_picker.sv
// Combinational round-robin picker: grants up to SLOTS requesters, scanning from start.
module rr_multi_picker #(
  parameter int N     = 4,
  parameter int SLOTS = 2,
  localparam int PTR_BITS = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_BITS = $clog2(SLOTS + 1)
) (
  input  logic [N-1:0]       req,
  input  logic [PTR_BITS-1:0] start,
  output logic [SLOTS*N-1:0] grant,
  output logic [SLOTS-1:0]   slot_valid,
  output logic [PTR_BITS-1:0] last_idx,
  output logic               any_grant
);

  logic [PTR_BITS:0]   pos;
  logic [PTR_BITS-1:0] idx;
  logic [CNT_BITS-1:0] cnt;

  // Walk the requesters in rotated order; the n-th hit lands in slot n.
  always_comb begin
    grant      = '0;
    slot_valid = '0;
    last_idx   = start;
    any_grant  = 1'b0;
    cnt        = '0;
    pos        = '0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, start} + (PTR_BITS+1)'(i);
      if (pos >= (PTR_BITS+1)'(N)) pos = pos - (PTR_BITS+1)'(N);
      idx = pos[PTR_BITS-1:0];
      if (req[idx] && (cnt < CNT_BITS'(SLOTS))) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (cnt == CNT_BITS'(s)) begin
            grant[s*N +: N] = N'(1) << idx;
            slot_valid[s]   = 1'b1;
          end
        end
        last_idx  = idx;
        any_grant = 1'b1;
        cnt       = cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry buffer per FU, round-robin grant onto SS registered broadcast slots.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int SS        = CDB_PORTS,
  parameter int FU_COUNT  = FU_COUNT_DEF,
  parameter int PREG_BITS = PREG_W,
  parameter int ROB_BITS  = ROB_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [FU_COUNT-1:0]           fu_valid,
  output logic [FU_COUNT-1:0]           fu_ready,
  input  logic [FU_COUNT*PREG_BITS-1:0] fu_rd,
  input  logic [FU_COUNT*ROB_BITS-1:0]  fu_rob_id,
  input  logic [FU_COUNT*32-1:0]        fu_value,
  output logic [SS-1:0]                 cdb_valid,
  output logic [SS*PREG_BITS-1:0]       cdb_rd,
  output logic [SS*ROB_BITS-1:0]        cdb_rob_id,
  output logic [SS*32-1:0]              cdb_value,
  output logic [SS-1:0]                 regf_we
);

  localparam int PTR_BITS = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  logic [FU_COUNT-1:0]    full, req, grant, load;
  logic [PREG_BITS-1:0]   buf_rd    [FU_COUNT];
  logic [ROB_BITS-1:0]    buf_rob   [FU_COUNT];
  logic [31:0]            buf_value [FU_COUNT];
  logic [SS*FU_COUNT-1:0] slot_grant;
  logic [SS-1:0]          slot_valid;
  logic [PTR_BITS-1:0]    rr_ptr, last_idx;
  logic                   any_grant;
  logic [PREG_BITS-1:0]   sel_rd    [SS];
  logic [ROB_BITS-1:0]    sel_rob   [SS];
  logic [31:0]            sel_value [SS];
  cdb_t                   cdb_q     [SS];

  // Flush masks every request so nothing is granted and rr_ptr holds.
  assign req = flush ? '0 : full;

  rr_multi_picker #(.N(FU_COUNT), .SLOTS(SS)) u_picker (
    .req        (req),
    .start      (rr_ptr),
    .grant      (slot_grant),
    .slot_valid (slot_valid),
    .last_idx   (last_idx),
    .any_grant  (any_grant)
  );

  always_comb begin
    grant = '0;
    for (int s = 0; s < SS; s++) grant = grant | slot_grant[s*FU_COUNT +: FU_COUNT];
  end

  assign fu_ready = flush ? '0 : (~full | grant);
  assign load     = fu_valid & fu_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       full <= '0;
    else if (flush) full <= '0;
    else            full <= load | (full & ~grant);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < FU_COUNT; k++) begin
      if (load[k]) begin
        buf_rd[k]    <= fu_rd[k*PREG_BITS +: PREG_BITS];
        buf_rob[k]   <= fu_rob_id[k*ROB_BITS +: ROB_BITS];
        buf_value[k] <= fu_value[k*32 +: 32];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < SS; s++) begin
      sel_rd[s]    = '0;
      sel_rob[s]   = '0;
      sel_value[s] = '0;
      for (int k = 0; k < FU_COUNT; k++) begin
        if (slot_grant[s*FU_COUNT + k]) begin
          sel_rd[s]    = sel_rd[s] | buf_rd[k];
          sel_rob[s]   = sel_rob[s] | buf_rob[k];
          sel_value[s] = sel_value[s] | buf_value[k];
        end
      end
    end
  end

  // Idle slots drop valid but keep their last payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SS; s++) cdb_q[s] <= '0;
    end else begin
      for (int s = 0; s < SS; s++) begin
        cdb_q[s].valid <= slot_valid[s];
        if (slot_valid[s]) begin
          cdb_q[s].rd     <= sel_rd[s];
          cdb_q[s].rob_id <= sel_rob[s];
          cdb_q[s].value  <= sel_value[s];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= '0;
    else if (any_grant)
      rr_ptr <= (last_idx == PTR_BITS'(FU_COUNT - 1)) ? '0 : last_idx + PTR_BITS'(1);
  end

  always_comb begin
    for (int s = 0; s < SS; s++) begin
      cdb_valid[s]                         = cdb_q[s].valid;
      cdb_rd[s*PREG_BITS +: PREG_BITS]     = cdb_q[s].rd;
      cdb_rob_id[s*ROB_BITS +: ROB_BITS]   = cdb_q[s].rob_id;
      cdb_value[s*32 +: 32]                = cdb_q[s].value;
      regf_we[s]                           = cdb_q[s].valid && (cdb_q[s].rd != '0);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with a broadcast scoreboard.
module tb_cdb_arbiter;

  localparam int FU = 4;
  localparam int SS = 2;
  localparam int PB = 6;
  localparam int RB = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic [FU-1:0]     fu_valid = '0;
  logic [FU-1:0]     fu_ready;
  logic [FU*PB-1:0]  fu_rd = '0;
  logic [FU*RB-1:0]  fu_rob_id = '0;
  logic [FU*32-1:0]  fu_value = '0;
  logic [SS-1:0]     cdb_valid;
  logic [SS*PB-1:0]  cdb_rd;
  logic [SS*RB-1:0]  cdb_rob_id;
  logic [SS*32-1:0]  cdb_value;
  logic [SS-1:0]     regf_we;

  typedef struct {
    int          slot;
    logic [PB-1:0] rd;
    logic [RB-1:0] rob;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_ready   (fu_ready),
    .fu_rd      (fu_rd),
    .fu_rob_id  (fu_rob_id),
    .fu_value   (fu_value),
    .cdb_valid  (cdb_valid),
    .cdb_rd     (cdb_rd),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .regf_we    (regf_we)
  );

  always #5 clk = ~clk;

  // Every valid slot seen on the bus must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      for (int s = 0; s < SS; s++) begin
        if (cdb_valid[s] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL unexpected_broadcast: slot %0d rd=%0d rob=%0d value=%h, none required",
                     s, cdb_rd[s*PB +: PB], cdb_rob_id[s*RB +: RB], cdb_value[s*32 +: 32]);
          end else begin
            e = exp_q.pop_front();
            if (e.slot != s || cdb_rd[s*PB +: PB] !== e.rd || cdb_rob_id[s*RB +: RB] !== e.rob ||
                cdb_value[s*32 +: 32] !== e.value || regf_we[s] !== (e.rd != '0)) begin
              n_bad++;
              $display("[TB] FAIL broadcast: got slot %0d rd=%0d rob=%0d value=%h we=%b, required slot %0d rd=%0d rob=%0d value=%h we=%b",
                       s, cdb_rd[s*PB +: PB], cdb_rob_id[s*RB +: RB], cdb_value[s*32 +: 32], regf_we[s],
                       e.slot, e.rd, e.rob, e.value, (e.rd != '0));
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int k, input logic [PB-1:0] rd, input logic [RB-1:0] rob, input logic [31:0] value);
    fu_rd[k*PB +: PB]     = rd;
    fu_rob_id[k*RB +: RB] = rob;
    fu_value[k*32 +: 32]  = value;
  endtask

  task automatic push(input int slot, input logic [PB-1:0] rd, input logic [RB-1:0] rob, input logic [31:0] value);
    exp_t e;
    e.slot = slot; e.rd = rd; e.rob = rob; e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (cdb_valid !== 2'b00 || regf_we !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got valid=%b we=%b, required 00/00", cdb_valid, regf_we);
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (fu_ready !== 4'b1111) begin
      n_bad++;
      $display("[TB] FAIL reset_ready: got %b, required 1111", fu_ready);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL idle_valid: got %b, required 00", cdb_valid);
    end
  endtask

  task automatic test_single();
    set_fu(0, 6'd5, 5'd3, 32'hDEADBEEF);
    push(0, 6'd5, 5'd3, 32'hDEADBEEF);
    fu_valid = 4'b0001;
    tick();
    fu_valid = '0;
    n_cmp++;
    if (cdb_valid !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL single_early: got valid=%b, required 00", cdb_valid);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 2'b01 || regf_we !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL single_latency: got valid=%b we=%b, required 01/01", cdb_valid, regf_we);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL single_after: got valid=%b, required 00", cdb_valid);
    end
  endtask

  task automatic test_reg_zero();
    set_fu(3, 6'd0, 5'd7, 32'h12345678);
    push(0, 6'd0, 5'd7, 32'h12345678);
    fu_valid = 4'b1000;
    tick();
    fu_valid = '0;
    tick();
    n_cmp++;
    if (cdb_valid !== 2'b01 || regf_we !== 2'b00 || cdb_rob_id[RB-1:0] !== 5'd7) begin
      n_bad++;
      $display("[TB] FAIL reg_zero: got valid=%b we=%b rob=%0d, required 01/00/7", cdb_valid, regf_we, cdb_rob_id[RB-1:0]);
    end
    tick();
  endtask

  task automatic test_all_four();
    for (int k = 0; k < FU; k++) set_fu(k, PB'(10 + k), RB'(20 + k), 32'hA0000000 + 32'(k));
    push(0, 6'd10, 5'd20, 32'hA0000000);
    push(1, 6'd11, 5'd21, 32'hA0000001);
    push(0, 6'd12, 5'd22, 32'hA0000002);
    push(1, 6'd13, 5'd23, 32'hA0000003);
    fu_valid = 4'b1111;
    tick();
    fu_valid = '0;
    n_cmp++;
    if (fu_ready !== 4'b0011) begin
      n_bad++;
      $display("[TB] FAIL all_ready: got %b, required 0011", fu_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== ((c < 2) ? 2'b11 : 2'b00)) begin
        n_bad++;
        $display("[TB] FAIL all_valid_c%0d: got %b, required %b", c, cdb_valid, (c < 2) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_fu(2, 6'd30, 5'd12, 32'h22222222);
    push(0, 6'd30, 5'd12, 32'h22222222);
    fu_valid = 4'b0100;
    tick();
    fu_valid = '0;
    tick();
    tick();
    set_fu(0, 6'd31, 5'd1, 32'h00000F00);
    set_fu(3, 6'd32, 5'd2, 32'h33330001);
    push(0, 6'd32, 5'd2, 32'h33330001);
    push(1, 6'd31, 5'd1, 32'h00000F00);
    push(0, 6'd33, 5'd4, 32'h33330002);
    fu_valid = 4'b1001;
    tick();
    set_fu(3, 6'd33, 5'd4, 32'h33330002);
    fu_valid = 4'b1000;
    #1;
    n_cmp++;
    if (fu_ready !== 4'b1111) begin
      n_bad++;
      $display("[TB] FAIL b2b_ready: got %b, required 1111", fu_ready);
    end
    tick();
    fu_valid = '0;
    n_cmp++;
    if (cdb_valid !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL b2b_pair: got %b, required 11", cdb_valid);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL b2b_refill: got %b, required 01", cdb_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    set_fu(1, 6'd40, 5'd9, 32'h11110000);
    push(0, 6'd40, 5'd9, 32'h11110000);
    fu_valid = 4'b0010;
    tick();
    fu_valid = '0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) set_fu(k, PB'(50 + k), RB'(k), 32'hBAD00000 + 32'(k));
    fu_valid = 4'b0111;
    tick();
    set_fu(3, 6'd55, 5'd5, 32'hBAD00003);
    fu_valid = 4'b1000;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (fu_ready !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL flush_ready: got %b, required 0000", fu_ready);
    end
    tick();
    flush = 1'b0;
    fu_valid = '0;
    #1;
    n_cmp++;
    if (cdb_valid !== 2'b00 || fu_ready !== 4'b1111) begin
      n_bad++;
      $display("[TB] FAIL flush_after: got valid=%b ready=%b, required 00/1111", cdb_valid, fu_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== 2'b00) begin
        n_bad++;
        $display("[TB] FAIL flush_stale_c%0d: got %b, required 00", c, cdb_valid);
      end
    end
    // rr_ptr stayed at 2 across the flush, so FU2/FU3 go first.
    for (int k = 0; k < FU; k++) set_fu(k, PB'(60 + k), RB'(24 + k), 32'hC0000000 + 32'(k));
    push(0, 6'd62, 5'd26, 32'hC0000002);
    push(1, 6'd63, 5'd27, 32'hC0000003);
    push(0, 6'd60, 5'd24, 32'hC0000000);
    push(1, 6'd61, 5'd25, 32'hC0000001);
    fu_valid = 4'b1111;
    tick();
    fu_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== ((c < 2) ? 2'b11 : 2'b00)) begin
        n_bad++;
        $display("[TB] FAIL post_flush_c%0d: got %b, required %b", c, cdb_valid, (c < 2) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) set_fu(k, PB'(1 + k), RB'(k), 32'h55550000 + 32'(k));
    fu_valid = 4'b0111;
    tick();
    fu_valid = '0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cdb_valid !== 2'b00 || regf_we !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL async_reset: got valid=%b we=%b, required 00/00", cdb_valid, regf_we);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (fu_ready !== 4'b1111) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_ready: got %b, required 1111", fu_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== 2'b00) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_stale_c%0d: got %b, required 00", c, cdb_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reg_zero();
    test_all_four();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
